// File: rtl/manticore_boot_pkg.sv
// Shared types and constants for the Manticore boot sequencer.
package manticore_boot_pkg;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_CORE_RESET = 3'd1,
        S_LOAD       = 3'd2,
        S_RUN        = 3'd3,
        S_DONE       = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        STATUS_NONE      = 3'd0,
        STATUS_PASS      = 3'd1,
        STATUS_FAIL      = 3'd2,
        STATUS_GMEM_FAIL = 3'd3,
        STATUS_BAD_IMAGE = 3'd4,
        STATUS_TIMEOUT   = 3'd5
    } status_t;

    localparam int unsigned PKT_ADDR_CTRL = 0;
    localparam int unsigned PKT_ADDR_BODY = 1;
    localparam logic [15:0] FAIL_ID_MIN   = 16'h8000;
    localparam int unsigned TAIL_WORDS    = 3;

    // Exception ids at or above FAIL_ID_MIN mean the program reported failure.
    function automatic logic is_fail_id(input logic [15:0] id);
        return (id >= FAIL_ID_MIN);
    endfunction

endpackage

// File: rtl/manticore_boot_streamer.sv
// LOAD-phase pipeline: issues program-memory reads back to back and turns the
// returned words into packets, one cycle after each read's data arrives.
module manticore_boot_streamer
    import manticore_boot_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int PKT_AW      = 11,
    parameter int MEM_AW      = 10,
    parameter int MAX_PROGRAM = 128
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start_i,
    input  logic [MEM_AW-1:0] base_i,
    output logic              mem_ren_o,
    output logic [MEM_AW-1:0] mem_raddr_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              pkt_valid_o,
    output logic [DATA_W-1:0] pkt_data_o,
    output logic [PKT_AW-1:0] pkt_addr_o,
    output logic              done_o,
    output logic              bad_image_o
);

    localparam int IDX_W = DATA_W + 2;

    logic              active_q, active_d;
    logic              ren_q, ren_d;
    logic [MEM_AW-1:0] raddr_q, raddr_d;
    logic [IDX_W-1:0]  cur_idx_q, cur_idx_d;
    logic              pend_q, pend_d;
    logic [IDX_W-1:0]  pend_idx_q, pend_idx_d;
    logic [DATA_W-1:0] n_q, n_d;
    logic              n_valid_q, n_valid_d;
    logic              pkt_valid_q, pkt_valid_d;
    logic [DATA_W-1:0] pkt_data_q, pkt_data_d;
    logic [PKT_AW-1:0] pkt_addr_q, pkt_addr_d;
    logic              done_q, done_d;
    logic              bad_q, bad_d;

    logic [IDX_W-1:0]  next_idx_s;
    logic [IDX_W-1:0]  last_idx_s;
    logic              more_s;

    // Indices 0..3 exist in every image, so reads run ahead of the N latch safely.
    always_comb begin
        next_idx_s = cur_idx_q + IDX_W'(1);
        last_idx_s = {n_q, 2'b00} + IDX_W'(TAIL_WORDS);
        more_s     = (next_idx_s <= IDX_W'(TAIL_WORDS)) ||
                     (n_valid_q && (next_idx_s <= last_idx_s));
    end

    // Next-state logic for the read-issue and packet-emit pipeline.
    always_comb begin
        active_d    = active_q;
        ren_d       = 1'b0;
        raddr_d     = raddr_q;
        cur_idx_d   = cur_idx_q;
        pend_d      = 1'b0;
        pend_idx_d  = pend_idx_q;
        n_d         = n_q;
        n_valid_d   = n_valid_q;
        pkt_valid_d = 1'b0;
        pkt_data_d  = '0;
        pkt_addr_d  = '0;
        done_d      = 1'b0;
        bad_d       = 1'b0;
        if (start_i) begin
            active_d  = 1'b1;
            ren_d     = 1'b1;
            raddr_d   = base_i;
            cur_idx_d = '0;
            n_d       = '0;
            n_valid_d = 1'b0;
        end else if (active_q) begin
            pend_d     = ren_q;
            pend_idx_d = cur_idx_q;
            if (ren_q && more_s) begin
                ren_d     = 1'b1;
                cur_idx_d = next_idx_s;
                raddr_d   = raddr_q + MEM_AW'(1);
            end else begin
                ren_d = 1'b0;
            end
            if (pend_q) begin
                if ((pend_idx_q == '0) && (mem_rdata_i > DATA_W'(MAX_PROGRAM))) begin
                    bad_d    = 1'b1;
                    active_d = 1'b0;
                    ren_d    = 1'b0;
                    pend_d   = 1'b0;
                end else begin
                    pkt_valid_d = 1'b1;
                    pkt_data_d  = mem_rdata_i;
                    pkt_addr_d  = ((pend_idx_q != '0) && (pend_idx_q <= {n_q, 2'b00}))
                                  ? PKT_AW'(PKT_ADDR_BODY) : PKT_AW'(PKT_ADDR_CTRL);
                    if (pend_idx_q == '0) begin
                        n_d       = mem_rdata_i;
                        n_valid_d = 1'b1;
                    end else begin
                        n_d = n_q;
                    end
                    if (n_valid_q && (pend_idx_q == last_idx_s)) begin
                        done_d   = 1'b1;
                        active_d = 1'b0;
                    end else begin
                        done_d = 1'b0;
                    end
                end
            end else begin
                pkt_valid_d = 1'b0;
            end
        end else begin
            ren_d = 1'b0;
        end
    end

    // Pipeline registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            active_q    <= 1'b0;
            ren_q       <= 1'b0;
            raddr_q     <= '0;
            cur_idx_q   <= '0;
            pend_q      <= 1'b0;
            pend_idx_q  <= '0;
            n_q         <= '0;
            n_valid_q   <= 1'b0;
            pkt_valid_q <= 1'b0;
            pkt_data_q  <= '0;
            pkt_addr_q  <= '0;
            done_q      <= 1'b0;
            bad_q       <= 1'b0;
        end else begin
            active_q    <= active_d;
            ren_q       <= ren_d;
            raddr_q     <= raddr_d;
            cur_idx_q   <= cur_idx_d;
            pend_q      <= pend_d;
            pend_idx_q  <= pend_idx_d;
            n_q         <= n_d;
            n_valid_q   <= n_valid_d;
            pkt_valid_q <= pkt_valid_d;
            pkt_data_q  <= pkt_data_d;
            pkt_addr_q  <= pkt_addr_d;
            done_q      <= done_d;
            bad_q       <= bad_d;
        end
    end

    assign mem_ren_o   = ren_q;
    assign mem_raddr_o = raddr_q;
    assign pkt_valid_o = pkt_valid_q;
    assign pkt_data_o  = pkt_data_q;
    assign pkt_addr_o  = pkt_addr_q;
    assign done_o      = done_q;
    assign bad_image_o = bad_q;

endmodule

// File: rtl/manticore_boot_sequencer.sv
// Boot and run controller for one Manticore core: reset hold, image streaming
// through the streamer, then supervision of the running program.
module manticore_boot_sequencer
    import manticore_boot_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int PKT_AW      = 11,
    parameter int MEM_AW      = 10,
    parameter int RESET_HOLD  = 10,
    parameter int MAX_PROGRAM = 128,
    parameter int RUN_TIMEOUT = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [MEM_AW-1:0] prog_base,
    output logic              mem_ren,
    output logic [MEM_AW-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              core_reset,
    output logic [DATA_W-1:0] packet_out_data,
    output logic [PKT_AW-1:0] packet_out_address,
    output logic              packet_out_valid,
    input  logic              gmem_failure,
    input  logic              exception_error,
    input  logic [15:0]       exception_id,
    output logic              busy,
    output logic              done,
    output logic [2:0]        status,
    output logic [15:0]       fail_id
);

    localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [31:0]       wdog_q, wdog_d;
    logic [MEM_AW-1:0] base_q, base_d;
    status_t           status_q, status_d;
    logic [15:0]       fail_id_q, fail_id_d;
    logic              core_reset_q, core_reset_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              stream_start_s;
    logic              stream_done_s;
    logic              stream_bad_s;

    manticore_boot_streamer #(
        .DATA_W      (DATA_W),
        .PKT_AW      (PKT_AW),
        .MEM_AW      (MEM_AW),
        .MAX_PROGRAM (MAX_PROGRAM)
    ) u_streamer (
        .clock       (clock),
        .reset       (reset),
        .start_i     (stream_start_s),
        .base_i      (base_q),
        .mem_ren_o   (mem_ren),
        .mem_raddr_o (mem_raddr),
        .mem_rdata_i (mem_rdata),
        .pkt_valid_o (packet_out_valid),
        .pkt_data_o  (packet_out_data),
        .pkt_addr_o  (packet_out_address),
        .done_o      (stream_done_s),
        .bad_image_o (stream_bad_s)
    );

    // Sequencer next-state and registered-output logic.
    always_comb begin
        state_d        = state_q;
        hold_d         = hold_q;
        wdog_d         = wdog_q;
        base_d         = base_q;
        status_d       = status_q;
        fail_id_d      = fail_id_q;
        core_reset_d   = core_reset_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        stream_start_s = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_CORE_RESET;
                    hold_d       = '0;
                    base_d       = prog_base;
                    status_d     = STATUS_NONE;
                    core_reset_d = 1'b1;
                    busy_d       = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            S_CORE_RESET: begin
                if (hold_q == HOLD_W'(RESET_HOLD - 1)) begin
                    state_d        = S_LOAD;
                    core_reset_d   = 1'b0;
                    stream_start_s = 1'b1;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            S_LOAD: begin
                if (stream_bad_s) begin
                    state_d  = S_DONE;
                    status_d = STATUS_BAD_IMAGE;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                end else if (stream_done_s) begin
                    state_d = S_RUN;
                    wdog_d  = '0;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_RUN: begin
                wdog_d = (wdog_q == 32'hFFFF_FFFF) ? wdog_q : wdog_q + 32'd1;
                // Termination checks in priority order; fail_id follows the winner.
                if (gmem_failure) begin
                    status_d  = STATUS_GMEM_FAIL;
                    fail_id_d = exception_id;
                end else if (exception_error) begin
                    status_d  = is_fail_id(exception_id) ? STATUS_FAIL : STATUS_PASS;
                    fail_id_d = exception_id;
                end else if ((RUN_TIMEOUT != 0) && (wdog_q >= 32'(RUN_TIMEOUT - 1))) begin
                    status_d  = STATUS_TIMEOUT;
                    fail_id_d = 16'h0000;
                end else begin
                    status_d = status_q;
                end
                if (gmem_failure || exception_error ||
                    ((RUN_TIMEOUT != 0) && (wdog_q >= 32'(RUN_TIMEOUT - 1)))) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d      = S_IDLE;
                core_reset_d = 1'b1;
                busy_d       = 1'b0;
            end
        endcase
    end

    // Sequencer state register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            hold_q       <= '0;
            wdog_q       <= '0;
            base_q       <= '0;
            status_q     <= STATUS_NONE;
            fail_id_q    <= 16'h0000;
            core_reset_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            wdog_q       <= wdog_d;
            base_q       <= base_d;
            status_q     <= status_d;
            fail_id_q    <= fail_id_d;
            core_reset_q <= core_reset_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign core_reset = core_reset_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign status     = status_q;
    assign fail_id    = fail_id_q;

endmodule

// File: tb/tb_manticore_boot_sequencer.sv
// Directed/randomized bench: a memory model plus image/packet/status reference
// built from the boot rules, compared cycle by cycle at the falling edge.
module tb_manticore_boot_sequencer;

    localparam int HOLD  = 10;
    localparam int MAXP  = 128;
    localparam int TMO   = 50;
    localparam int MSIZE = 1024;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  prog_base = '0;
    logic        mem_ren;
    logic [9:0]  mem_raddr;
    logic [15:0] mem_rdata = '0;
    logic        core_reset;
    logic [15:0] packet_out_data;
    logic [10:0] packet_out_address;
    logic        packet_out_valid;
    logic        gmem_failure = 1'b0;
    logic        exception_error = 1'b0;
    logic [15:0] exception_id = '0;
    logic        busy;
    logic        done;
    logic [2:0]  status;
    logic [15:0] fail_id;

    logic [15:0] mem [MSIZE];
    int n_cmp = 0;
    int n_mis = 0;

    manticore_boot_sequencer #(
        .DATA_W(16), .PKT_AW(11), .MEM_AW(10),
        .RESET_HOLD(HOLD), .MAX_PROGRAM(MAXP), .RUN_TIMEOUT(TMO)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .prog_base(prog_base),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .core_reset(core_reset), .packet_out_data(packet_out_data),
        .packet_out_address(packet_out_address), .packet_out_valid(packet_out_valid),
        .gmem_failure(gmem_failure), .exception_error(exception_error),
        .exception_id(exception_id), .busy(busy), .done(done),
        .status(status), .fail_id(fail_id)
    );

    always #5 clock = ~clock;

    // Synchronous program memory: data one cycle after the read enable.
    always @(posedge clock) begin
        if (mem_ren) mem_rdata <= mem[mem_raddr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_status(input bit g, input bit e, input logic [15:0] id);
        if (g) return 3;
        if (e) return (id >= 16'h8000) ? 2 : 1;
        return 0;
    endfunction

    task automatic load_image(input int base, input int n);
        mem[base % MSIZE] = 16'(n);
        if (n <= MAXP)
            for (int k = 1; k <= 4 * n + 3; k++) mem[(base + k) % MSIZE] = 16'($urandom);
    endtask

    // Starts a boot and checks reset hold, read start and every packet.
    task automatic boot(input int base, input int n, input bit poke_start);
        int t = 4 * n + 4;
        @(negedge clock);
        start = 1'b1;
        prog_base = 10'(base);
        @(negedge clock);
        start = 1'b0;
        for (int h = 0; h < HOLD; h++) begin
            if (h > 0) @(negedge clock);
            gmem_failure    = (h < HOLD - 1);
            exception_error = (h < HOLD - 1);
            chk("hold_core_reset", core_reset, 1);
            chk("hold_valid", packet_out_valid, 0);
            if (h == 0) begin
                chk("start_busy", busy, 1);
                chk("start_status_none", status, 0);
            end
        end
        @(negedge clock);
        chk("l0_core_reset", core_reset, 0);
        chk("l0_ren", mem_ren, 1);
        chk("l0_raddr", mem_raddr, 32'(base % MSIZE));
        @(negedge clock);
        chk("l1_valid", packet_out_valid, 0);
        if (n > MAXP) begin
            @(negedge clock);
            chk("bad_valid0", packet_out_valid, 0);
            @(negedge clock);
            chk("bad_valid1", packet_out_valid, 0);
            chk("bad_done", done, 1);
            chk("bad_status", status, 4);
            chk("bad_busy", busy, 0);
            return;
        end
        for (int k = 0; k < t; k++) begin
            @(negedge clock);
            if (poke_start) start = (k == 2);
            chk("pkt_valid", packet_out_valid, 1);
            chk("pkt_addr", packet_out_address, (k >= 1 && k <= 4 * n) ? 1 : 0);
            chk("pkt_data", packet_out_data, 32'(mem[(base + k) % MSIZE]));
        end
        start = 1'b0;
        @(negedge clock);
        chk("run_valid", packet_out_valid, 0);
        chk("run_busy", busy, 1);
        chk("run_ren", mem_ren, 0);
        chk("run_done", done, 0);
    endtask

    // Drives one RUN-phase event and checks the termination report.
    task automatic finish_run(input bit g, input bit e, input logic [15:0] id);
        int es = exp_status(g, e, id);
        gmem_failure    = g;
        exception_error = e;
        exception_id    = id;
        @(negedge clock);
        gmem_failure    = 1'b0;
        exception_error = 1'b0;
        chk("term_done", done, 1);
        chk("term_status", status, es);
        chk("term_fail_id", fail_id, 32'(id));
        chk("term_busy", busy, 0);
        chk("term_core_reset", core_reset, 0);
        @(negedge clock);
        chk("done_pulse", done, 0);
        chk("status_held", status, es);
    endtask

    initial begin
        int base;
        int n;
        int c;
        bit g;
        for (int i = 0; i < MSIZE; i++) mem[i] = 16'($urandom);
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_core_reset", core_reset, 1);
        chk("rst_valid", packet_out_valid, 0);
        chk("rst_data", packet_out_data, 0);
        chk("rst_addr", packet_out_address, 0);
        chk("rst_ren", mem_ren, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_status", status, 0);
        chk("rst_fail_id", fail_id, 0);
        reset = 1'b0;

        load_image(0, 7);
        boot(0, 7, 1'b0);
        finish_run(1'b0, 1'b1, 16'h0003);
        boot(0, 7, 1'b0);
        finish_run(1'b0, 1'b1, 16'h8005);
        boot(0, 7, 1'b0);
        finish_run(1'b1, 1'b1, 16'h8005);

        base = int'($urandom_range(0, MSIZE - 1));
        load_image(base, 0);
        boot(base, 0, 1'b0);
        finish_run(1'b0, 1'b1, 16'($urandom_range(0, 16'h7FFF)));

        load_image(300, MAXP + 1);
        boot(300, MAXP + 1, 1'b0);

        load_image(200, MAXP);
        boot(200, MAXP, 1'b0);
        finish_run(1'b0, 1'b1, 16'($urandom_range(16'h8000, 16'hFFFF)));

        n = int'($urandom_range(1, 6));
        load_image(40, n);
        boot(40, n, 1'b0);
        c = 0;
        while (c < 200) begin
            @(negedge clock);
            c++;
            if (done) break;
        end
        chk("timeout_cycles", c, TMO);
        chk("timeout_status", status, 5);
        chk("timeout_fail_id", fail_id, 0);

        load_image(MSIZE - 2, 3);
        boot(MSIZE - 2, 3, 1'b0);
        finish_run(1'b0, 1'b1, 16'h0042);

        load_image(100, 5);
        @(negedge clock);
        start = 1'b1;
        prog_base = 10'd100;
        @(negedge clock);
        start = 1'b0;
        repeat (HOLD + 5) @(negedge clock);
        chk("midload_valid_before", packet_out_valid, 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("abort_valid", packet_out_valid, 0);
        chk("abort_core_reset", core_reset, 1);
        chk("abort_busy", busy, 0);
        chk("abort_ren", mem_ren, 0);
        repeat (3) @(negedge clock);
        chk("abort_quiet", packet_out_valid, 0);
        boot(100, 5, 1'b1);
        finish_run(1'b0, 1'b1, 16'h0001);

        for (int r = 0; r < 4; r++) begin
            base = int'($urandom_range(0, MSIZE - 1));
            n = int'($urandom_range(0, 20));
            load_image(base, n);
            boot(base, n, r[0]);
            g = 1'($urandom_range(0, 1));
            finish_run(g, g ? 1'($urandom_range(0, 1)) : 1'b1, 16'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
